// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bus for store_align_unit.
// The unit sits on the slave modport. The pipeline and memory side sit on the master modport.
`timescale 1ns/1ps
interface store_align_unit_if #(
  parameter int WIDTH = 32
);
  logic             st_valid;
  logic             st_ready;
  logic [WIDTH-1:0] st_addr;
  logic [WIDTH-1:0] st_data;
  logic [1:0]       st_size;
  logic             mem_valid;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             st_done;
  logic             ades;
  logic [WIDTH-1:0] bad_vaddr;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_we, mem_wdata, st_done, ades, bad_vaddr
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_we, mem_wdata, st_done, ades, bad_vaddr
  );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment unit: converts a byte-addressed store into a registered, lane-enabled
// data-memory write request, and flags misaligned stores with an address-error pulse.
`timescale 1ns/1ps
module store_align_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  store_align_unit_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] addr_q, wdata_q, bad_vaddr_q;
  logic [3:0]       we_q;
  logic             done_q, ades_q;

  logic [1:0]       off;
  logic [3:0]       we_nxt;
  logic [WIDTH-1:0] wdata_nxt;
  logic             misaligned;
  logic             mem_valid_int;
  logic             st_ready_int;
  logic             xfer;
  logic             load;

  assign off  = bus.st_addr[1:0];
  assign xfer = bus.st_valid & st_ready_int;
  assign load = xfer & ~misaligned;

  // Lane decode: the byte-enable codes match the ones the load path uses.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    we_nxt     = 4'b0000;
    wdata_nxt  = bus.st_data;
    misaligned = 1'b0;
    case (bus.st_size)
      2'b00: begin
        we_nxt    = 4'b0001 << off;
        wdata_nxt = {4{bus.st_data[7:0]}};
      end
      2'b01: begin
        misaligned = off[0];
        we_nxt     = off[1] ? 4'b1100 : 4'b0011;
        wdata_nxt  = {2{bus.st_data[15:0]}};
      end
      2'b10: begin
        misaligned = (off != 2'b00);
        we_nxt     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = WAIT;
      WAIT: if (bus.mem_ready) state_nxt = load ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The request registers are cleared on reset so that the memory-side outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      ades_q      <= 1'b0;
      bad_vaddr_q <= '0;
    end else begin
      done_q <= mem_valid_int & bus.mem_ready;
      ades_q <= xfer & misaligned;
      if (xfer & misaligned) bad_vaddr_q <= bus.st_addr;
      if (load) begin
        addr_q  <= {bus.st_addr[WIDTH-1:2], 2'b00};
        we_q    <= we_nxt;
        wdata_q <= wdata_nxt;
      end
    end
  end

  // mem_we is gated by mem_valid, so it reads 0 in IDLE whatever we_q holds.
  always_comb begin
    mem_valid_int = (state == WAIT);
    st_ready_int  = ~mem_valid_int | bus.mem_ready;
    bus.st_ready  = st_ready_int;
    bus.mem_valid = mem_valid_int;
    bus.mem_addr  = addr_q;
    bus.mem_we    = mem_valid_int ? we_q : 4'b0000;
    bus.mem_wdata = wdata_q;
    bus.st_done   = done_q;
    bus.ades      = ades_q;
    bus.bad_vaddr = bad_vaddr_q;
  end

endmodule
